// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared datapath width, immediate format and ALU command encodings
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } immsrc_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_cmd_t;

endpackage

// File: rtl/riscv_imm_ext.sv
// rtl/riscv_imm_ext.sv - combinational immediate extractor for I/S/B/U/J formats
module riscv_imm_ext
  import riscv_pkg::*;
(
  input  logic [31:7]     inst,
  input  logic [2:0]      immsrc,
  output logic [XLEN-1:0] imm_ext
);

  logic s;
  assign s = inst[31];

  always_comb begin
    imm_ext = '0;
    case (immsrc_e'(immsrc))
      IMM_I:   imm_ext = {{20{s}}, inst[31:20]};
      IMM_S:   imm_ext = {{20{s}}, inst[31:25], inst[11:7]};
      IMM_B:   imm_ext = {{19{s}}, s, inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm_ext = {inst[31:12], 12'b0};
      IMM_J:   imm_ext = {{11{s}}, s, inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

endmodule

// File: rtl/riscv_exec_unit.sv
// rtl/riscv_exec_unit.sv - registered execute stage: immediate, operand mux, RV32I ALU, zero flag
// Optional result inversion enabled by defining EXEC_ALU_INV_EN.
module riscv_exec_unit
  import riscv_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [31:0]     i_inst,
  input  logic [2:0]      i_immsrc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_alu_src_sel,
  input  logic            i_alu_inv,
  input  logic [3:0]      i_alu_cmd,
  output logic [XLEN-1:0] o_imm_ext,
  output logic [XLEN-1:0] o_alu_result,
  output logic            o_zero_f
);

`ifdef EXEC_ALU_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      shamt;
  logic [XLEN-1:0] raw;
  logic            inv_eff;
  logic            unused_opcode;

  // Opcode bits carry no immediate data.
  assign unused_opcode = ^i_inst[6:0];

  riscv_imm_ext u_imm_ext (
    .inst    (i_inst[31:7]),
    .immsrc  (i_immsrc),
    .imm_ext (imm_ext)
  );

  assign op_a    = i_rs1_data;
  assign op_b    = i_alu_src_sel ? imm_ext : i_rs2_data;
  assign shamt   = op_b[4:0];
  assign inv_eff = i_alu_inv & INV_EN;

  always_comb begin
    raw = '0;
    case (alu_cmd_t'(i_alu_cmd))
      ALU_ADD:  raw = op_a + op_b;
      ALU_SUB:  raw = op_a - op_b;
      ALU_SLL:  raw = op_a << shamt;
      ALU_SLT:  raw = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: raw = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_XOR:  raw = op_a ^ op_b;
      ALU_SRL:  raw = op_a >> shamt;
      ALU_SRA:  raw = XLEN'($signed(op_a) >>> shamt);
      ALU_OR:   raw = op_a | op_b;
      ALU_AND:  raw = op_a & op_b;
      default:  raw = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_imm_ext    <= '0;
      o_alu_result <= '0;
      o_zero_f     <= 1'b1;
    end else if (i_en) begin
      o_imm_ext    <= imm_ext;
      o_alu_result <= inv_eff ? ~raw : raw;
      o_zero_f     <= (raw == '0);
    end
  end

endmodule

// File: tb/tb_riscv_exec_unit.sv
// tb/tb_riscv_exec_unit.sv - vector table, corner sequences and randomized reference-model checks
module tb_riscv_exec_unit;

`ifdef EXEC_ALU_INV_EN
  localparam bit INV_ON = 1'b1;
`else
  localparam bit INV_ON = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_en;
  logic [31:0] i_inst;
  logic [2:0]  i_immsrc;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic        i_alu_src_sel;
  logic        i_alu_inv;
  logic [3:0]  i_alu_cmd;
  logic [31:0] o_imm_ext;
  logic [31:0] o_alu_result;
  logic        o_zero_f;

  int checks = 0;
  int errors = 0;

  riscv_exec_unit dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_en          (i_en),
    .i_inst        (i_inst),
    .i_immsrc      (i_immsrc),
    .i_rs1_data    (i_rs1_data),
    .i_rs2_data    (i_rs2_data),
    .i_alu_src_sel (i_alu_src_sel),
    .i_alu_inv     (i_alu_inv),
    .i_alu_cmd     (i_alu_cmd),
    .o_imm_ext     (o_imm_ext),
    .o_alu_result  (o_alu_result),
    .o_zero_f      (o_zero_f)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [2:0]  immsrc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        sel;
    logic        inv;
    logic [3:0]  cmd;
    logic [31:0] exp_imm;
    logic [31:0] exp_raw;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Immediate built from the field layout, sign extension by signed arithmetic.
  function automatic logic [31:0] ref_imm(input logic [31:0] inst, input int src);
    logic signed [11:0] f12;
    logic signed [19:0] f20;
    case (src)
      0: return 32'($signed(inst) >>> 20);
      1: return (32'($signed(inst) >>> 20) & 32'hFFFF_FFE0) | {27'b0, inst[11:7]};
      2: begin
        f12 = {inst[31], inst[7], inst[30:25], inst[11:8]};
        return 32'(int'(f12) * 2);
      end
      3: return inst & 32'hFFFF_F000;
      4: begin
        f20 = {inst[31], inst[19:12], inst[20], inst[30:21]};
        return 32'(int'(f20) * 2);
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input int cmd);
    longint la, lb, pw;
    int     sa, sb, sh;
    la = longint'({32'b0, a});
    lb = longint'({32'b0, b});
    sa = int'(a);
    sb = int'(b);
    sh = int'(b % 32);
    pw = longint'(1) << sh;
    case (cmd)
      0: return 32'(la + lb);
      1: return 32'(la - lb);
      2: return 32'(la * pw);
      3: return (sa < sb) ? 32'd1 : 32'd0;
      4: return (la < lb) ? 32'd1 : 32'd0;
      5: return a ^ b;
      6: return 32'(la / pw);
      7: return 32'(sa >>> sh);
      8: return a | b;
      9: return a & b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive(input logic [31:0] inst, input logic [2:0] src, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic sel, input logic inv, input logic [3:0] cmd);
    i_inst = inst; i_immsrc = src; i_rs1_data = rs1; i_rs2_data = rs2;
    i_alu_src_sel = sel; i_alu_inv = inv; i_alu_cmd = cmd;
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_outputs(input string name, input logic [31:0] e_imm, input logic [31:0] e_raw,
                               input logic inv);
    chk({name, "_imm"}, o_imm_ext, e_imm);
    chk({name, "_res"}, o_alu_result, (inv && INV_ON) ? ~e_raw : e_raw);
    chk({name, "_zero"}, {31'b0, o_zero_f}, {31'b0, e_raw == 32'h0});
  endtask

  initial begin
    logic [31:0] r_inst, r_rs1, r_rs2, e_imm, e_b;
    logic [2:0]  r_src;
    logic [3:0]  r_cmd;
    logic        r_sel, r_inv;

    vecs[0]  = '{"addi",     32'hFFF00093, 3'd0, 32'd5,        32'd0,        1'b1, 1'b0, 4'd0,  32'hFFFF_FFFF, 32'd4};
    vecs[1]  = '{"bimm",     32'hFE000EE3, 3'd2, 32'd0,        32'd0,        1'b1, 1'b0, 4'd0,  32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[2]  = '{"sub_eq",   32'h4020C1B3, 3'd0, 32'h1234,     32'h1234,     1'b0, 1'b0, 4'd1,  32'h0000_0402, 32'h0};
    vecs[3]  = '{"sub_inv",  32'h4020C1B3, 3'd0, 32'h1234,     32'h1234,     1'b0, 1'b1, 4'd1,  32'h0000_0402, 32'h0};
    vecs[4]  = '{"slt",      32'h0,        3'd0, 32'hFFFF_FFFF, 32'd1,       1'b0, 1'b0, 4'd3,  32'h0,         32'd1};
    vecs[5]  = '{"sltu",     32'h0,        3'd0, 32'hFFFF_FFFF, 32'd1,       1'b0, 1'b0, 4'd4,  32'h0,         32'd0};
    vecs[6]  = '{"sra",      32'h0,        3'd0, 32'h8000_0000, 32'h24,      1'b0, 1'b0, 4'd7,  32'h0,         32'hF800_0000};
    vecs[7]  = '{"srl",      32'h0,        3'd0, 32'h8000_0000, 32'h24,      1'b0, 1'b0, 4'd6,  32'h0,         32'h0800_0000};
    vecs[8]  = '{"sll",      32'h0,        3'd0, 32'h8000_0000, 32'h24,      1'b0, 1'b0, 4'd2,  32'h0,         32'h0};
    vecs[9]  = '{"uimm",     32'h12345037, 3'd3, 32'd1,         32'd0,       1'b1, 1'b0, 4'd8,  32'h1234_5000, 32'h1234_5001};
    vecs[10] = '{"jimm",     32'hFFDFF06F, 3'd4, 32'd8,         32'd0,       1'b1, 1'b0, 4'd0,  32'hFFFF_FFFC, 32'd4};
    vecs[11] = '{"simm",     32'h8E112423, 3'd1, 32'hF0,        32'd0,       1'b1, 1'b0, 4'd9,  32'hFFFF_F8E8, 32'hE0};
    vecs[12] = '{"bad_imm",  32'hFFFF_FFFF, 3'd7, 32'd3,        32'd0,       1'b1, 1'b0, 4'd0,  32'h0,         32'd3};
    vecs[13] = '{"bad_cmd",  32'h0,        3'd0, 32'h55,        32'h66,      1'b0, 1'b0, 4'd12, 32'h0,         32'h0};
    vecs[14] = '{"xor",      32'h0,        3'd0, 32'hA5A5_0F0F, 32'hFFFF_0000, 1'b0, 1'b0, 4'd5, 32'h0,        32'h5A5A_0F0F};
    vecs[15] = '{"add_wrap", 32'h0,        3'd0, 32'hFFFF_FFFF, 32'd1,       1'b0, 1'b1, 4'd0,  32'h0,         32'h0};

    i_rst = 1'b0;
    i_en  = 1'b0;
    drive(32'h0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);
    #12;
    check_outputs("reset", 32'h0, 32'h0, 1'b0);

    // Release reset with enable low: nothing may move.
    drive(32'hFFF00093, 3'd0, 32'd5, 32'd0, 1'b1, 1'b0, 4'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    tick();
    tick();
    check_outputs("rel_hold", 32'h0, 32'h0, 1'b0);

    i_en = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].inst, vecs[i].immsrc, vecs[i].rs1, vecs[i].rs2, vecs[i].sel, vecs[i].inv, vecs[i].cmd);
      tick();
      check_outputs(vecs[i].name, vecs[i].exp_imm, vecs[i].exp_raw, vecs[i].inv);
    end

    // Enable low: outputs keep the last captured operation.
    drive(32'hFFF00093, 3'd0, 32'd5, 32'd0, 1'b1, 1'b0, 4'd0);
    tick();
    i_en = 1'b0;
    drive(32'h12345037, 3'd3, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
    tick();
    tick();
    check_outputs("en_hold", 32'hFFFF_FFFF, 32'd4, 1'b0);

    // Mid-cycle asynchronous reset clears without a clock edge.
    #2;
    i_rst = 1'b0;
    #1;
    check_outputs("async_rst", 32'h0, 32'h0, 1'b0);
    #2;
    i_rst = 1'b1;
    i_en  = 1'b1;
    tick();

    for (int n = 0; n < 300; n++) begin
      r_inst = $urandom;
      r_src  = 3'($urandom_range(0, 7));
      r_rs1  = $urandom;
      r_rs2  = ($urandom_range(0, 3) == 0) ? r_rs1 : $urandom;
      r_sel  = 1'($urandom_range(0, 1));
      r_inv  = 1'($urandom_range(0, 1));
      r_cmd  = 4'($urandom_range(0, 15));
      drive(r_inst, r_src, r_rs1, r_rs2, r_sel, r_inv, r_cmd);
      tick();
      e_imm = ref_imm(r_inst, int'(r_src));
      e_b   = r_sel ? e_imm : r_rs2;
      check_outputs("rand", e_imm, ref_alu(r_rs1, e_b, int'(r_cmd)), r_inv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
